// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer/FIFO-side bus of the FIFO write-port arbiter.
//   REQ/DATA     : N_REQ producers presenting words (DATA lane i = [i*WIDTH +: WIDTH])
//   ACK          : one-hot per-beat acknowledge back to the producers
//   GNT/GNT_ID   : registered one-hot grant and owner index
//   FIFO_FULL    : FULL flag from the FIFO
//   FIFO_WR_EN   : write strobe to the FIFO
//   FIFO_DATA    : write data to the FIFO
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding environment (producers plus the FIFO write side)
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       REQ;
    logic [N_REQ*WIDTH-1:0] DATA;
    logic [N_REQ-1:0]       ACK;
    logic [N_REQ-1:0]       GNT;
    logic [ID_W-1:0]        GNT_ID;
    logic                   FIFO_FULL;
    logic                   FIFO_WR_EN;
    logic [WIDTH-1:0]       FIFO_DATA;

    modport slave (
        input  REQ, DATA, FIFO_FULL,
        output ACK, GNT, GNT_ID, FIFO_WR_EN, FIFO_DATA
    );

    modport master (
        output REQ, DATA, FIFO_FULL,
        input  ACK, GNT, GNT_ID, FIFO_WR_EN, FIFO_DATA
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one sync FIFO write port among N_REQ producers.
// Round-robin arbitration with a bounded burst (MAX_BURST beats per tenure).
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous, active-low reset
//   bus  : fifo_wr_arbiter_if.slave (REQ, DATA, ACK, GNT, GNT_ID,
//          FIFO_FULL, FIFO_WR_EN, FIFO_DATA)

// Per-requester slice: acknowledge generation and data select for the
// AND-OR write-data mux.
module fifo_wr_arbiter_lane #(
    parameter int WIDTH = 8
) (
    input  logic             own,
    input  logic             sel,
    input  logic             xfer,
    input  logic [WIDTH-1:0] data,
    output logic             ack,
    output logic [WIDTH-1:0] data_sel
);
    assign ack      = own & xfer;
    assign data_sel = sel ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic             CLK,
    input  logic             RST,
    fifo_wr_arbiter_if.slave bus
);
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t                        state, state_nxt;
    logic [N_REQ-1:0]              gnt, gnt_nxt;
    logic [ID_W-1:0]               gnt_id, gnt_id_nxt;
    logic [ID_W-1:0]               last, last_nxt;
    logic [CNT_W-1:0]              beat, beat_nxt;

    logic [N_REQ-1:0][WIDTH-1:0]   data_v;
    logic [N_REQ-1:0][WIDTH-1:0]   lane_data;
    logic [N_REQ-1:0]              ack;
    logic [WIDTH-1:0]              fifo_data;

    logic                          xfer;
    logic                          rel;
    logic [ID_W-1:0]               base;
    logic [ID_W-1:0]               cand;
    logic [ID_W-1:0]               win_id;
    logic                          win_vld;

    assign data_v = bus.DATA;

    // A beat moves only when the owner presents a word and the FIFO has room.
    assign xfer = (state == OWN) && bus.REQ[gnt_id] && !bus.FIFO_FULL;

    // Release on a full burst or when the owner withdraws. A FULL stall
    // alone never releases, so grant timing stays independent of FULL.
    assign rel = (state == OWN) &&
                 ((xfer && (beat == LAST_BEAT)) || !bus.REQ[gnt_id]);

    // Circular search starting after the last-served index. On a release in
    // OWN the owner becomes "last", so search from gnt_id. Scanning from the
    // far end lets the nearest requester overwrite earlier hits; the owner
    // itself is the final candidate so a lone requester is re-granted.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        base    = (state == OWN) ? gnt_id : last;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(base) + k) % N_REQ);
            if (bus.REQ[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        last_nxt   = last;
        beat_nxt   = beat;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt  = OWN;
                    gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_nxt = win_id;
                    beat_nxt   = '0;
                end
            end
            OWN: begin
                if (rel) begin
                    last_nxt = gnt_id;
                    beat_nxt = '0;
                    if (win_vld) begin
                        gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
                        gnt_id_nxt = win_id;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (xfer) begin
                    beat_nxt = beat + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            last   <= ID_W'(N_REQ - 1);
            beat   <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
            last   <= last_nxt;
            beat   <= beat_nxt;
        end
    end

    // Lane i is selected by index, not by the one-hot grant, so FIFO_DATA
    // follows GNT_ID even while idle or stalled.
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        fifo_wr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
            .own      (gnt[i]),
            .sel      (gnt_id == ID_W'(i)),
            .xfer     (xfer),
            .data     (data_v[i]),
            .ack      (ack[i]),
            .data_sel (lane_data[i])
        );
    end

    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fifo_data = fifo_data | lane_data[i];
        end
    end

    assign bus.ACK        = ack;
    assign bus.GNT        = gnt;
    assign bus.GNT_ID     = gnt_id;
    assign bus.FIFO_WR_EN = xfer;
    assign bus.FIFO_DATA  = fifo_data;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8,
// MAX_BURST=4). A cycle table covers single-requester bursts, early release,
// FULL stalls and release-while-full; hand sequences cover async reset,
// round-robin fairness and integration with an 8-deep FIFO model.
module tb_fifo_wr_arbiter;
    localparam int N_REQ     = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    fifo_wr_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        full;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic [3:0]  ack;
        logic        wr;
        logic [7:0]  fd;
        logic        chk_sel;   // compare GNT_ID/FIFO_DATA only where defined
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, input logic [31:0] data,
                                input logic full, input logic [3:0] gnt,
                                input logic [1:0] id, input logic [3:0] ack,
                                input logic wr, input logic [7:0] fd,
                                input logic chk_sel);
        vec_t v;
        v.req = req; v.data = data; v.full = full; v.gnt = gnt; v.id = id;
        v.ack = ack; v.wr = wr; v.fd = fd; v.chk_sel = chk_sel;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #2;
        RST = 1'b1;
    endtask

    vec_t        tbl[26];
    int          cnt[4];
    logic [31:0] d;
    logic [7:0]  fq[$];
    logic [7:0]  popped[$];
    logic [7:0]  exp_order[12];
    int          sent0, sent1, writes, stall, pops;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //          req    data          full gnt   id    ack   wr  fd     chk
        tbl[0]  = mk(4'h1, 32'h00000001, 0, 4'h0, 2'd0, 4'h0, 0, 8'h01, 1);
        tbl[1]  = mk(4'h1, 32'h00000001, 0, 4'h1, 2'd0, 4'h1, 1, 8'h01, 1);
        tbl[2]  = mk(4'h1, 32'h00000002, 0, 4'h1, 2'd0, 4'h1, 1, 8'h02, 1);
        tbl[3]  = mk(4'h1, 32'h00000003, 0, 4'h1, 2'd0, 4'h1, 1, 8'h03, 1);
        tbl[4]  = mk(4'h1, 32'h00000004, 0, 4'h1, 2'd0, 4'h1, 1, 8'h04, 1);
        tbl[5]  = mk(4'h1, 32'h00000005, 0, 4'h1, 2'd0, 4'h1, 1, 8'h05, 1);
        tbl[6]  = mk(4'h1, 32'h00000006, 0, 4'h1, 2'd0, 4'h1, 1, 8'h06, 1);
        tbl[7]  = mk(4'h0, 32'h00000006, 0, 4'h1, 2'd0, 4'h0, 0, 8'h06, 1);
        tbl[8]  = mk(4'hC, 32'h31210000, 0, 4'h0, 2'd0, 4'h0, 0, 8'h00, 0);
        tbl[9]  = mk(4'hC, 32'h31210000, 0, 4'h4, 2'd2, 4'h4, 1, 8'h21, 1);
        tbl[10] = mk(4'hC, 32'h31220000, 0, 4'h4, 2'd2, 4'h4, 1, 8'h22, 1);
        tbl[11] = mk(4'h8, 32'h31220000, 0, 4'h4, 2'd2, 4'h0, 0, 8'h22, 1);
        tbl[12] = mk(4'h8, 32'h31220000, 0, 4'h8, 2'd3, 4'h8, 1, 8'h31, 1);
        tbl[13] = mk(4'h2, 32'h31221100, 0, 4'h8, 2'd3, 4'h0, 0, 8'h31, 1);
        tbl[14] = mk(4'h2, 32'h31221100, 0, 4'h2, 2'd1, 4'h2, 1, 8'h11, 1);
        tbl[15] = mk(4'h2, 32'h31221200, 0, 4'h2, 2'd1, 4'h2, 1, 8'h12, 1);
        tbl[16] = mk(4'h2, 32'h31221300, 1, 4'h2, 2'd1, 4'h0, 0, 8'h13, 1);
        tbl[17] = mk(4'h2, 32'h31221300, 1, 4'h2, 2'd1, 4'h0, 0, 8'h13, 1);
        tbl[18] = mk(4'h2, 32'h31221300, 1, 4'h2, 2'd1, 4'h0, 0, 8'h13, 1);
        tbl[19] = mk(4'h2, 32'h31221300, 0, 4'h2, 2'd1, 4'h2, 1, 8'h13, 1);
        tbl[20] = mk(4'h3, 32'h31221405, 0, 4'h2, 2'd1, 4'h2, 1, 8'h14, 1);
        tbl[21] = mk(4'h3, 32'h31221505, 0, 4'h1, 2'd0, 4'h1, 1, 8'h05, 1);
        tbl[22] = mk(4'h2, 32'h31221505, 1, 4'h1, 2'd0, 4'h0, 0, 8'h05, 1);
        tbl[23] = mk(4'h2, 32'h31221505, 0, 4'h2, 2'd1, 4'h2, 1, 8'h15, 1);
        tbl[24] = mk(4'h0, 32'h31221505, 0, 4'h2, 2'd1, 4'h0, 0, 8'h15, 1);
        tbl[25] = mk(4'h0, 32'h31221505, 0, 4'h0, 2'd0, 4'h0, 0, 8'h00, 0);

        exp_order = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                      8'hA4, 8'hA5, 8'hB4, 8'hB5};

        // Power-on reset
        RST           = 1'b1;
        bus.REQ       = '0;
        bus.DATA      = '0;
        bus.FIFO_FULL = 1'b0;
        #1 RST = 1'b0;
        #2;
        chk("reset GNT",        32'(bus.GNT), 32'h0);
        chk("reset GNT_ID",     32'(bus.GNT_ID), 32'h0);
        chk("reset ACK",        32'(bus.ACK), 32'h0);
        chk("reset FIFO_WR_EN", 32'(bus.FIFO_WR_EN), 32'h0);
        #9 RST = 1'b1;
        tick();

        // Cycle table
        for (int r = 0; r < 26; r++) begin
            bus.REQ       = tbl[r].req;
            bus.DATA      = tbl[r].data;
            bus.FIFO_FULL = tbl[r].full;
            #4;
            chk($sformatf("row%0d GNT", r),   32'(bus.GNT), 32'(tbl[r].gnt));
            chk($sformatf("row%0d ACK", r),   32'(bus.ACK), 32'(tbl[r].ack));
            chk($sformatf("row%0d WR_EN", r), 32'(bus.FIFO_WR_EN), 32'(tbl[r].wr));
            if (tbl[r].chk_sel) begin
                chk($sformatf("row%0d GNT_ID", r), 32'(bus.GNT_ID), 32'(tbl[r].id));
                chk($sformatf("row%0d FIFO_DATA", r), 32'(bus.FIFO_DATA), 32'(tbl[r].fd));
            end
            tick();
        end

        // Async reset mid-burst
        bus.REQ  = 4'b0010;
        bus.DATA = 32'h00004400;
        tick();
        chk("pre-reset GNT",   32'(bus.GNT), 32'h2);
        chk("pre-reset WR_EN", 32'(bus.FIFO_WR_EN), 32'h1);
        #2 RST = 1'b0;
        #1;
        chk("async reset GNT",    32'(bus.GNT), 32'h0);
        chk("async reset GNT_ID", 32'(bus.GNT_ID), 32'h0);
        chk("async reset ACK",    32'(bus.ACK), 32'h0);
        chk("async reset WR_EN",  32'(bus.FIFO_WR_EN), 32'h0);
        bus.REQ = 4'b0011;
        #2 RST = 1'b1;
        tick();
        chk("post-reset GNT",    32'(bus.GNT), 32'h1);
        chk("post-reset GNT_ID", 32'(bus.GNT_ID), 32'h0);
        bus.REQ = '0;
        tick();
        chk("post-reset idle GNT", 32'(bus.GNT), 32'h0);

        // Round-robin with all four requesting
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c <= 20; c++) begin
            bus.REQ = 4'hF;
            for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(i * 16 + cnt[i]);
            bus.DATA      = d;
            bus.FIFO_FULL = 1'b0;
            #4;
            if (c == 0) begin
                chk("rr grant latency WR_EN", 32'(bus.FIFO_WR_EN), 32'h0);
            end else begin
                int k, own, exp_w;
                k     = c - 1;
                own   = (k / 4) % 4;
                exp_w = own * 16 + (k / 16) * 4 + k % 4;
                chk($sformatf("rr beat%0d WR_EN", k),  32'(bus.FIFO_WR_EN), 32'h1);
                chk($sformatf("rr beat%0d GNT_ID", k), 32'(bus.GNT_ID), 32'(own));
                chk($sformatf("rr beat%0d ACK", k),    32'(bus.ACK), 32'(1 << own));
                chk($sformatf("rr beat%0d data", k),   32'(bus.FIFO_DATA), 32'(exp_w));
            end
            for (int i = 0; i < 4; i++) if (bus.ACK[i]) cnt[i]++;
            tick();
        end
        bus.REQ = '0;
        tick();

        // Integration with an 8-deep FIFO model
        do_reset();
        sent0 = 0; sent1 = 0; writes = 0; stall = 0; pops = 0;
        for (int c = 0; c < 100 && writes < 12; c++) begin
            bus.REQ       = {2'b00, sent1 < 6, sent0 < 6};
            bus.DATA      = {16'h0, 8'(8'hB0 + sent1), 8'(8'hA0 + sent0)};
            bus.FIFO_FULL = (fq.size() == 8);
            #4;
            if (bus.FIFO_FULL) begin
                if (stall == 0) chk("int writes before stall", 32'(writes), 32'd8);
                chk("int stall WR_EN", 32'(bus.FIFO_WR_EN), 32'h0);
                chk("int stall ACK",   32'(bus.ACK), 32'h0);
                stall++;
            end
            if (bus.FIFO_WR_EN === 1'b1) begin
                if (fq.size() < 8) fq.push_back(bus.FIFO_DATA);
                writes++;
            end
            if (bus.ACK[0]) sent0++;
            if (bus.ACK[1]) sent1++;
            if (stall >= 3 && pops < 4) begin
                popped.push_back(fq.pop_front());
                pops++;
            end
            tick();
        end
        bus.REQ = '0;
        chk("int total writes", 32'(writes), 32'd12);
        chk("int stall cycles", 32'(stall), 32'd3);
        while (fq.size() > 0) popped.push_back(fq.pop_front());
        chk("int popped count", 32'(popped.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < popped.size())
                chk($sformatf("int pop%0d", i), 32'(popped[i]), 32'(exp_order[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one sync FIFO write port among N_REQ producers.
- Arbitration is round-robin with a bounded burst length.
- Drives the FIFO's WR_EN/DATA_IN and honours its FULL flag; each producer gets a per-beat ACK.
- Sits directly in front of the FIFO write side. The read side is untouched.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, data width; matches the FIFO WIDTH
- MAX_BURST, 4, max accepted beats per grant tenure (1..255)
- ID_W, $clog2(N_REQ), width of the grant index

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- REQ  in  N_REQ  per-requester request; held high while a word is presented
- DATA  in  N_REQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- ACK  out  N_REQ  one-hot; bit i high in the cycle requester i's word is written
- GNT  out  N_REQ  registered one-hot grant (all-zero = idle)
- GNT_ID  out  ID_W  index of current owner (valid when GNT != 0)
- FIFO_FULL  in  1  FULL from the FIFO
- FIFO_WR_EN  out  1  to FIFO WR_EN
- FIFO_DATA  out  WIDTH  to FIFO DATA_IN

Behaviour:
- Reset (RST low, async):
  - GNT=0, GNT_ID=0, state=IDLE, beat count=0.
  - Last-served pointer=N_REQ-1, so requester 0 has first priority.
  - ACK=0, FIFO_WR_EN=0.
  - A reset mid-burst drops the grant immediately. The interrupted word is not written.
- Transfer condition (combinational):
  - xfer = (GNT!=0) && REQ[GNT_ID] && !FIFO_FULL.
  - FIFO_WR_EN = xfer.
  - ACK[GNT_ID] = xfer; all other ACK bits are 0.
  - FIFO_DATA = DATA slice of GNT_ID, also driven while not transferring.
- Producer rule: DATA must stay stable while REQ is high and ACK is low. After an ACK the next word, if any, is presented in the next cycle.
- FSM states: IDLE and OWN.
  - IDLE: if any REQ is high at the clock edge, grant the first requester with REQ high, searching from last+1 circularly. GNT/GNT_ID update at that edge, state goes to OWN, beat count=0.
    - Grant latency from REQ rising in IDLE: 1 cycle. The first possible write is the cycle after the REQ edge.
  - OWN: on each xfer, beat count increments. The grant is released at an edge when either:
    - (a) xfer and beat count == MAX_BURST-1; or
    - (b) REQ[GNT_ID] is low.
  - On release:
    - last := GNT_ID, beat count := 0.
    - Re-arbitrate in the same edge from last+1, using the REQ vector sampled at that edge.
    - If a winner exists, go to OWN with the new grant, with no idle cycle.
    - Otherwise GNT := 0 and state goes to IDLE.
  - When the owner is the only requester at a MAX_BURST release, it is re-granted back-to-back with no bubble. Its beat count restarts at 0.
- FIFO_FULL high: xfer=0, no ACK, beat count holds, grant holds. A stall never forces a release.
  - If the owner drops REQ while FULL, release per rule (b).
- Fairness: with all requesters continuously requesting and the FIFO never full, service order is 0,1,...,N_REQ-1,0,... and each tenure is exactly MAX_BURST beats.
- Requests for non-owners are ignored until re-arbitration. ACK only ever goes to the current owner.
- Beat counter width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 at a clock edge.
- No combinational path from FIFO_FULL to GNT. GNT and GNT_ID are always registered.

Test Plan:
- Reset: RST low mid-simulation with GNT=0010 -> GNT=0, GNT_ID=0, ACK=0, FIFO_WR_EN=0 immediately (async). After release, REQ=0001 is granted requester 0 first.
- Single requester: REQ=0001, DATA0 = 1,2,...,6 advanced on each ACK, MAX_BURST=4 -> 6 consecutive FIFO_WR_EN cycles starting 1 cycle after REQ, FIFO contents 1..6, GNT stays 0001 throughout.
- Round-robin: REQ=1111 held, each requester streams its own ID*16+n -> grants in order 0,1,2,3,0 with 4 beats each. FIFO_WR_EN continuous with no idle cycles; the first 16 words are 0x00..0x03, 0x10..0x13, 0x20..0x23, 0x30..0x33.
- Early release: requester 2 drops REQ after 2 beats while REQ[3]=1 -> GNT moves to 1000 at that edge, and requester 3 writes in the next cycle.
- FIFO full stall: FIFO_FULL=1 for 3 cycles while requester 1 owns with beat count=2 -> no ACK, no FIFO_WR_EN, GNT unchanged. After FULL drops, exactly 2 more beats are accepted, then the grant releases.
- Integration with an 8-deep sync FIFO: REQ=0011, 12 words total -> 8 writes accepted, stall at FULL. After 4 FIFO pops, the remaining 4 writes complete. Popped order matches the grant order and no word is lost or duplicated.
